fixed_order_select_ctrl: RTL

Frame-level controller that sequences one block of samples through the bank of fixed-predictor encoders (orders 0..4). It issues encoder reset and enable, and flushes the encoder pipeline. It accumulates |residual| per order with correct latency alignment and warm-up exclusion, then selects the cheapest order. It sits between the sample framer and the residual coder.

---
 rtl/fixed_order_select_ctrl_if.sv | 43 ++++
 rtl/fixed_order_select_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fixed_order_select_ctrl_if.sv
// fixed_order_select_ctrl_if
// Bundles the framer, encoder-bank and result signals of the fixed-order
// selection controller.
//   master : sample source / encoder bank / result consumer side
//   slave  : the controller
// Signals:
//   start, block_size       block request (block_size latched on accepted start)
//   sample, valid, ready    sample handshake from the framer
//   enc_reset, enc_enable,  encoder bank control and data
//   enc_sample
//   residuals               encoder outputs, order o at [16o+15:16o]
//   busy, done              status; done is a one-cycle pulse
//   best_order, best_sum    selected order and its |residual| total
interface fixed_order_select_ctrl_if #(
  parameter int NUM_ORDERS = 5,
  parameter int SUM_W      = 32
);
  logic                      start;
  logic [15:0]               block_size;
  logic signed [15:0]        sample;
  logic                      valid;
  logic                      ready;
  logic                      enc_reset;
  logic                      enc_enable;
  logic signed [15:0]        enc_sample;
  logic [16*NUM_ORDERS-1:0]  residuals;
  logic                      busy;
  logic                      done;
  logic [2:0]                best_order;
  logic [SUM_W-1:0]          best_sum;

  modport master (
    output start, block_size, sample, valid, residuals,
    input  ready, enc_reset, enc_enable, enc_sample, busy, done,
           best_order, best_sum
  );

  modport slave (
    input  start, block_size, sample, valid, residuals,
    output ready, enc_reset, enc_enable, enc_sample, busy, done,
           best_order, best_sum
  );
endinterface

// File: rtl/fixed_order_select_ctrl.sv
// fixed_order_select_ctrl
// Runs one block of samples through the fixed-predictor encoder bank
// (orders 0..NUM_ORDERS-1), flushes the encoder pipeline, accumulates
// |residual| per order with latency alignment and warm-up exclusion, then
// picks the cheapest order (ties go to the lower order).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fixed_order_select_ctrl_if.slave (see interface header)
// Build option:
//   FIXED_SEL_SATURATE_EN  accumulators saturate at 2^SUM_W-1 instead of
//                          wrapping modulo 2^SUM_W.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | encoder reset, counters and accumulators cleared
// FILL   | accepting the block's samples
// FLUSH  | LATENCY zero-sample enables to drain the encoder pipeline
// SELECT | one order compared per cycle, ascending
// DONE   | result pulse
module fixed_order_select_ctrl #(
  parameter int LATENCY    = 8,
  parameter int NUM_ORDERS = 5,
  parameter int SUM_W      = 32
) (
  input logic                      clk,
  input logic                      rst_n,
  fixed_order_select_ctrl_if.slave bus
);

  localparam int ADD_W = ((SUM_W > 17) ? SUM_W : 17) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FILL, S_FLUSH, S_SELECT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0]      n_lat;
  logic [16:0]      en_cnt;
  logic [15:0]      smp_cnt;
  logic [7:0]       flush_cnt;
  logic [2:0]       sel_idx;
  logic [2:0]       cur_order;
  logic [SUM_W-1:0] cur_sum;
  logic [2:0]       best_order_q;
  logic [SUM_W-1:0] best_sum_q;

  logic [SUM_W-1:0] acc     [NUM_ORDERS];
  logic [SUM_W-1:0] acc_sum [NUM_ORDERS];
  logic             acc_hit [NUM_ORDERS];

  logic             accept;
  logic             last_accept;
  logic             flush_tc;
  logic             select_last;
  logic [SUM_W-1:0] sel_acc;
  logic             sel_ok;
  logic [2:0]       best_order_nxt;
  logic [SUM_W-1:0] best_sum_nxt;

  assign accept      = (state == S_FILL) && bus.valid;
  assign last_accept = accept && (smp_cnt == n_lat - 16'd1);
  assign flush_tc    = (flush_cnt == 8'd0);
  assign select_last = (sel_idx == 3'(NUM_ORDERS - 1));

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_CLEAR;
      S_CLEAR:  state_nxt = (n_lat == 16'd0) ? S_SELECT : S_FILL;
      S_FILL:   if (last_accept) state_nxt = S_FLUSH;
      S_FLUSH:  if (flush_tc) state_nxt = S_SELECT;
      S_SELECT: if (select_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    bus.ready      = (state == S_FILL);
    bus.enc_reset  = (state == S_CLEAR);
    bus.enc_enable = accept || (state == S_FLUSH);
    bus.enc_sample = accept ? bus.sample : 16'sd0;
    bus.busy       = (state != S_IDLE);
    bus.done       = (state == S_DONE);
    bus.best_order = best_order_q;
    bus.best_sum   = best_sum_q;
  end

  // ---------------- per-order |residual| accumulation ----------------
  // An enable with pre-increment count n presents the residual of sample
  // k = n - LATENCY; only k in [o, N-1] is a real, warmed-up residual.
  for (genvar o = 0; o < NUM_ORDERS; o++) begin : g_acc
    logic [16:0]      ext;
    logic [16:0]      mag;
    logic [ADD_W-1:0] sum_full;

    assign ext      = {bus.residuals[16*o+15], bus.residuals[16*o +: 16]};
    assign mag      = ext[16] ? (~ext + 17'd1) : ext;
    assign sum_full = ADD_W'(acc[o]) + ADD_W'(mag);
    assign acc_hit[o] = (en_cnt >= 17'(LATENCY + o)) &&
                        (en_cnt < ({1'b0, n_lat} + 17'(LATENCY)));
`ifdef FIXED_SEL_SATURATE_EN
    assign acc_sum[o] = (|sum_full[ADD_W-1:SUM_W]) ? {SUM_W{1'b1}}
                                                    : sum_full[SUM_W-1:0];
`else
    logic unused_carry;
    assign unused_carry = ^sum_full[ADD_W-1:SUM_W];
    assign acc_sum[o]   = sum_full[SUM_W-1:0];
`endif
  end

  // ---------------- selection compare ----------------
  always_comb begin
    sel_acc = acc[0];
    for (int o = 0; o < NUM_ORDERS; o++) begin
      if (sel_idx == 3'(o)) sel_acc = acc[o];
    end
    sel_ok         = ({13'd0, sel_idx} < n_lat);
    best_order_nxt = cur_order;
    best_sum_nxt   = cur_sum;
    // order 0 seeds the search unconditionally, so an empty block gives 0/0
    if (sel_idx == 3'd0) begin
      best_order_nxt = 3'd0;
      best_sum_nxt   = acc[0];
    end else if (sel_ok && (sel_acc < cur_sum)) begin
      best_order_nxt = sel_idx;
      best_sum_nxt   = sel_acc;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat        <= '0;
      en_cnt       <= '0;
      smp_cnt      <= '0;
      flush_cnt    <= '0;
      sel_idx      <= '0;
      cur_order    <= '0;
      cur_sum      <= '0;
      best_order_q <= '0;
      best_sum_q   <= '0;
      for (int o = 0; o < NUM_ORDERS; o++) acc[o] <= '0;
    end else begin
      if ((state == S_IDLE) && bus.start) n_lat <= bus.block_size;

      if (state == S_CLEAR) begin
        en_cnt       <= '0;
        smp_cnt      <= '0;
        flush_cnt    <= 8'(LATENCY - 1);
        sel_idx      <= '0;
        cur_order    <= '0;
        cur_sum      <= '0;
        best_order_q <= '0;
        best_sum_q   <= '0;
        for (int o = 0; o < NUM_ORDERS; o++) acc[o] <= '0;
      end else begin
        if (bus.enc_enable) en_cnt <= en_cnt + 17'd1;
        if (accept) smp_cnt <= smp_cnt + 16'd1;
        if (state == S_FLUSH) flush_cnt <= flush_cnt - 8'd1;
        for (int o = 0; o < NUM_ORDERS; o++) begin
          if (bus.enc_enable && acc_hit[o]) acc[o] <= acc_sum[o];
        end
        if (state == S_SELECT) begin
          sel_idx   <= sel_idx + 3'd1;
          cur_order <= best_order_nxt;
          cur_sum   <= best_sum_nxt;
          if (select_last) begin
            best_order_q <= best_order_nxt;
            best_sum_q   <= best_sum_nxt;
          end
        end
      end
    end
  end

endmodule
